// File: rtl/cnt_pair_pkg.sv
// Shared definitions for the counter_with_two_cnt frame sequencer:
// state encoding and default parameter values.
package cnt_pair_pkg;

    localparam int N_DEF       = 3;
    localparam int TO_W_DEF    = 4;
    localparam int TIMEOUT_DEF = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CLR   = ST_CLR,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        DONE  = ST_DONE,
        ERR   = ST_ERR
    } state_t;

endpackage

// File: rtl/cnt_pair_sequencer_if.sv
// Control/status bundle between the sequencer, its event sources and the counter.
interface cnt_pair_sequencer_if;

    logic start;
    logic ev;
    logic hold;
    logic abort;
    logic co;
    logic clr;
    logic cnt1;
    logic cnt2;
    logic busy;
    logic done;
    logic err;

    // Sequencer side.
    modport slave (
        input  start, ev, hold, abort, co,
        output clr, cnt1, cnt2, busy, done, err
    );

    // Event source / counter side.
    modport master (
        output start, ev, hold, abort, co,
        input  clr, cnt1, cnt2, busy, done, err
    );

endinterface

// File: rtl/cnt_pair_watchdog.sv
// Stall watchdog: clears on demand, counts RUN cycles without a counted event,
// flags expiry when the count reaches TIMEOUT-1.
module cnt_pair_watchdog #(
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [TO_W-1:0] wd_q;
    logic [TO_W-1:0] wd_d;

    always_comb begin
        wd_d = wd_q;
        if (clr_i) begin
            wd_d = '0;
        end else if (inc_i) begin
            wd_d = wd_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign expire_o = (wd_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/counter_with_two_cnt.sv
// N-bit datapath counter: sync clear has priority, counts when both enables are high,
// co flags the terminal count combinationally.
module counter_with_two_cnt #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         cnt1_i,
    input  logic         cnt2_i,
    output logic         co_o,
    output logic [N-1:0] count_o
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (cnt1_i && cnt2_i) begin
            count_d = count_q + N'(1);
        end
    end

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign co_o    = (count_q == '1);
    assign count_o = count_q;

endmodule

// File: rtl/cnt_pair_sequencer.sv
// Frame sequencer for counter_with_two_cnt: clears the counter, gates counting with
// ev/hold, reports frame completion (done) and event-stream stalls (err).
module cnt_pair_sequencer
    import cnt_pair_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TO_W    = TO_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                  clk,
    input logic                  rst,
    cnt_pair_sequencer_if.slave  bus
);

    if (N < 1 || TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_param_check
        $error("cnt_pair_sequencer: illegal N/TIMEOUT/TO_W combination");
    end

    state_t state_q;
    state_t state_d;

    logic clr;
    logic cnt1;
    logic cnt2;
    logic busy;
    logic done;
    logic err;
    logic wd_clr;
    logic wd_inc;
    logic wd_expire;
    logic abort_act;

    assign abort_act = bus.abort && (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = CLR;
                CLR:     state_d = RUN;
                RUN: begin
                    if (bus.hold) begin
                        state_d = PAUSE;
                    end else if (bus.ev && bus.co) begin
                        state_d = DONE;
                    end else if (!bus.ev && wd_expire) begin
                        state_d = ERR;
                    end
                end
                PAUSE:   if (!bus.hold) state_d = RUN;
                DONE:    state_d = IDLE;
                ERR:     if (bus.start) state_d = CLR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        clr    = 1'b0;
        cnt1   = 1'b0;
        cnt2   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        wd_clr = 1'b0;
        wd_inc = 1'b0;
        case (state_q)
            CLR: begin
                clr    = 1'b1;
                busy   = 1'b1;
                wd_clr = 1'b1;
            end
            RUN: begin
                cnt1   = 1'b1;
                cnt2   = bus.ev && !bus.hold;
                busy   = 1'b1;
                wd_clr = bus.ev && !bus.hold;
                wd_inc = !bus.ev && !bus.hold;
            end
            PAUSE:   busy = 1'b1;
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
        // Abort clears the counter in the same cycle it is seen.
        if (abort_act) begin
            clr = 1'b1;
        end
    end

    cnt_pair_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .inc_i    (wd_inc),
        .expire_o (wd_expire)
    );

    assign bus.clr  = clr;
    assign bus.cnt1 = cnt1;
    assign bus.cnt2 = cnt2;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err  = err;

endmodule

// File: tb/tb_cnt_pair_sequencer.sv
// Directed bench: sequencer driving a 3-bit counter_with_two_cnt, expected values
// worked out by hand from the frame timing (cycle 0 = cycle in which start is high).
module tb_cnt_pair_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    int         n_checks = 0;
    int         n_bad    = 0;

    cnt_pair_sequencer_if bus ();

    cnt_pair_sequencer #(
        .N       (3),
        .TO_W    (4),
        .TIMEOUT (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    counter_with_two_cnt #(
        .N (3)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.clr),
        .cnt1_i  (bus.cnt1),
        .cnt2_i  (bus.cnt2),
        .co_o    (bus.co),
        .count_o (count)
    );

    always #19 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance into the next cycle; inputs are driven afterwards, outputs sampled 1 later.
    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    // Cycles 0 and 1 of a frame: start in IDLE, then the one-cycle clear.
    task automatic begin_frame(input logic ev_v);
        tick();
        bus.start = 1'b1;
        bus.ev    = ev_v;
        #1;
        check("c0_busy", 32'(bus.busy), 32'(0));
        tick();
        bus.start = 1'b0;
        #1;
        check("c1_clr", 32'(bus.clr), 32'(1));
        check("c1_busy", 32'(bus.busy), 32'(1));
        check("c1_cnt1", 32'(bus.cnt1), 32'(0));
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ev    = 1'b0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        #50;
        check("rst_clr", 32'(bus.clr), 32'(0));
        check("rst_cnt1", 32'(bus.cnt1), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_err", 32'(bus.err), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1: full frame with ev held high; counts in cycles 2..9, done at 10.
        begin_frame(1'b1);
        for (int c = 2; c <= 9; c++) begin
            tick();
            #1;
            check("t1_cnt1", 32'(bus.cnt1), 32'(1));
            check("t1_cnt2", 32'(bus.cnt2), 32'(1));
            check("t1_count", 32'(count), 32'(c - 2));
            check("t1_nodone", 32'(bus.done), 32'(0));
        end
        tick();
        #1;
        check("t1_done", 32'(bus.done), 32'(1));
        check("t1_busy", 32'(bus.busy), 32'(0));
        check("t1_wrap", 32'(count), 32'(0));

        // 2: hold over cycles 6..7 stalls counting for cycles 6,7,8; done at 13.
        begin_frame(1'b1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            #1;
            check("t2_count", 32'(count), 32'(c - 2));
        end
        tick();
        bus.hold = 1'b1;
        #1;
        check("t2_c6_cnt2", 32'(bus.cnt2), 32'(0));
        check("t2_c6_count", 32'(count), 32'(4));
        tick();
        #1;
        check("t2_c7_cnt1", 32'(bus.cnt1), 32'(0));
        check("t2_c7_busy", 32'(bus.busy), 32'(1));
        check("t2_c7_count", 32'(count), 32'(4));
        tick();
        bus.hold = 1'b0;
        #1;
        check("t2_c8_cnt1", 32'(bus.cnt1), 32'(0));
        check("t2_c8_count", 32'(count), 32'(4));
        for (int c = 9; c <= 12; c++) begin
            tick();
            #1;
            check("t2_run_count", 32'(count), 32'(c - 5));
            check("t2_nodone", 32'(bus.done), 32'(0));
        end
        tick();
        #1;
        check("t2_done", 32'(bus.done), 32'(1));
        bus.ev = 1'b0;

        // 3: no events; RUN cycles 2..11, err from cycle 12 until the next start.
        begin_frame(1'b0);
        for (int c = 2; c <= 11; c++) begin
            tick();
            #1;
            check("t3_run_cnt1", 32'(bus.cnt1), 32'(1));
            check("t3_run_err", 32'(bus.err), 32'(0));
        end
        for (int c = 12; c <= 15; c++) begin
            tick();
            #1;
            check("t3_err", 32'(bus.err), 32'(1));
            check("t3_err_cnt1", 32'(bus.cnt1), 32'(0));
            check("t3_err_busy", 32'(bus.busy), 32'(0));
        end
        tick();
        bus.start = 1'b1;
        #1;
        check("t3_err_at_start", 32'(bus.err), 32'(1));
        tick();
        bus.start = 1'b0;
        #1;
        check("t3_err_cleared", 32'(bus.err), 32'(0));
        check("t3_restart_clr", 32'(bus.clr), 32'(1));
        tick();
        bus.abort = 1'b1;
        #1;
        check("t3_abort_clr", 32'(bus.clr), 32'(1));
        tick();
        bus.abort = 1'b0;
        #1;
        check("t3_idle_busy", 32'(bus.busy), 32'(0));

        // 4: abort once the count reaches 5 (cycle 7).
        begin_frame(1'b1);
        for (int c = 2; c <= 6; c++) tick();
        tick();
        bus.abort = 1'b1;
        #1;
        check("t4_count5", 32'(count), 32'(5));
        check("t4_abort_clr", 32'(bus.clr), 32'(1));
        tick();
        bus.abort = 1'b0;
        bus.ev    = 1'b0;
        #1;
        check("t4_idle_busy", 32'(bus.busy), 32'(0));
        check("t4_count0", 32'(count), 32'(0));
        check("t4_nodone", 32'(bus.done), 32'(0));
        tick();
        #1;
        check("t4_nodone2", 32'(bus.done), 32'(0));

        // 6: start during RUN ignored; ev together with hold not counted, goes to PAUSE.
        begin_frame(1'b1);
        tick();
        tick();
        tick();
        bus.start = 1'b1;
        #1;
        check("t6_count2", 32'(count), 32'(2));
        check("t6_start_noclr", 32'(bus.clr), 32'(0));
        check("t6_start_cnt2", 32'(bus.cnt2), 32'(1));
        tick();
        bus.start = 1'b0;
        bus.hold  = 1'b1;
        #1;
        check("t6_count3", 32'(count), 32'(3));
        check("t6_hold_cnt2", 32'(bus.cnt2), 32'(0));
        tick();
        #1;
        check("t6_pause_count", 32'(count), 32'(3));
        check("t6_pause_cnt1", 32'(bus.cnt1), 32'(0));
        check("t6_pause_busy", 32'(bus.busy), 32'(1));
        tick();
        bus.hold  = 1'b0;
        bus.abort = 1'b1;
        #1;
        check("t6_abort_clr", 32'(bus.clr), 32'(1));
        tick();
        bus.abort = 1'b0;
        #1;
        check("t6_idle_busy", 32'(bus.busy), 32'(0));
        check("t6_count0", 32'(count), 32'(0));

        // 5: async reset mid-RUN, between clock edges.
        begin_frame(1'b1);
        tick();
        tick();
        #5;
        check("t5_pre_busy", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        #1;
        check("t5_clr", 32'(bus.clr), 32'(0));
        check("t5_cnt1", 32'(bus.cnt1), 32'(0));
        check("t5_cnt2", 32'(bus.cnt2), 32'(0));
        check("t5_busy", 32'(bus.busy), 32'(0));
        check("t5_done", 32'(bus.done), 32'(0));
        check("t5_err", 32'(bus.err), 32'(0));
        check("t5_count", 32'(count), 32'(0));
        @(negedge clk);
        rst    = 1'b0;
        bus.ev = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
